// File: rtl/mycpu_pkg.sv
// Shared constants and helpers for the decode-side fetch receiver.
// Opcode values, reset PC and branch offset extension.
package mycpu_pkg;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  function automatic logic [31:0] sext_br_offset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mycpu_br_cmp.sv
// Conditional branch comparator.
// Pure combinational: opcode plus operands give taken.
module mycpu_br_cmp
  import mycpu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output logic        taken
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_value == 32'd0);
  assign rs_neg  = rs_value[31];

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (op == OP_BEQ):  taken = (rs_value == rt_value);
      (op == OP_BNE):  taken = (rs_value != rt_value);
      (op == OP_BLEZ): taken = rs_neg || rs_zero;
      (op == OP_BGTZ): taken = !rs_neg && !rs_zero;
      default:         taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mycpu_id_fetch_rx.sv
// ID-stage receiver for instruction SRAM responses.
// Holds one overflow word while EX stalls; resolves branches.
module mycpu_id_fetch_rx
  import mycpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mycpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        allowIN,
  output logic        jen,
  output logic [31:0] offset,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        es_allowin,
  output logic        ds_to_es_valid,
  output logic [31:0] ds_inst,
  output logic [31:0] ds_pc
);

  logic        req_pending_q, req_pending_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_inst_q, ds_inst_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        br_done_q, br_done_d;

  logic        resp;
  logic        ds_allowin;
  logic        ds_load;
  logic        taken;

  assign resp       = req_pending_q;
  assign ds_allowin = !ds_valid_q || es_allowin;

  mycpu_br_cmp u_br_cmp (
    .op       (ds_inst_q[31:26]),
    .rs_value (rs_value),
    .rt_value (rt_value),
    .taken    (taken)
  );

  assign jen            = ds_valid_q && taken && !br_done_q;
  assign offset         = sext_br_offset(ds_inst_q[15:0]);
  assign rs_addr        = ds_inst_q[25:21];
  assign rt_addr        = ds_inst_q[20:16];
  assign ds_to_es_valid = ds_valid_q;
  assign ds_inst        = ds_inst_q;
  assign ds_pc          = ds_pc_q;
  assign allowIN        = !hold_valid_q && !(req_pending_q && !ds_allowin);

  always_comb begin
    req_pending_d = inst_sram_en;
    req_pc_d      = inst_sram_en ? inst_sram_addr : req_pc_q;
    ds_load       = 1'b0;
    ds_inst_d     = ds_inst_q;
    ds_pc_d       = ds_pc_q;
    hold_valid_d  = hold_valid_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    // The hold entry is older than any arriving word, so it goes first.
    if (hold_valid_q && ds_allowin) begin
      ds_load   = 1'b1;
      ds_inst_d = hold_inst_q;
      ds_pc_d   = hold_pc_q;
      if (resp) begin
        hold_inst_d = inst_sram_rdata;
        hold_pc_d   = req_pc_q;
      end else begin
        hold_valid_d = 1'b0;
      end
    end else if (resp && ds_allowin) begin
      ds_load   = 1'b1;
      ds_inst_d = inst_sram_rdata;
      ds_pc_d   = req_pc_q;
    end else if (resp) begin
      hold_valid_d = 1'b1;
      hold_inst_d  = inst_sram_rdata;
      hold_pc_d    = req_pc_q;
    end
    ds_valid_d = ds_load ? 1'b1 : (es_allowin ? 1'b0 : ds_valid_q);
    br_done_d  = ds_load ? 1'b0
               : ((jen && !es_allowin) ? 1'b1 : br_done_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_pending_q <= 1'b0;
      req_pc_q      <= RESET_PC;
      ds_valid_q    <= 1'b0;
      ds_inst_q     <= 32'd0;
      ds_pc_q       <= RESET_PC;
      hold_valid_q  <= 1'b0;
      hold_inst_q   <= 32'd0;
      hold_pc_q     <= RESET_PC;
      br_done_q     <= 1'b0;
    end else begin
      req_pending_q <= req_pending_d;
      req_pc_q      <= req_pc_d;
      ds_valid_q    <= ds_valid_d;
      ds_inst_q     <= ds_inst_d;
      ds_pc_q       <= ds_pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      br_done_q     <= br_done_d;
    end
  end

  a_no_overrun: assert property (
    @(posedge clk) disable iff (!resetn)
    !(req_pending_q && hold_valid_q && !ds_allowin)
  );

endmodule

// File: tb/tb_mycpu_id_fetch_rx.sv
// Bench for mycpu_id_fetch_rx: branch vector table, hand sequences
// and a random fetch/stall run against an in-order queue model.
module tb_mycpu_id_fetch_rx;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = 32'd0;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic        allowIN;
  logic        jen;
  logic [31:0] offset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        es_allowin = 1'b1;
  logic        ds_to_es_valid;
  logic [31:0] ds_inst;
  logic [31:0] ds_pc;

  always #5 clk = ~clk;

  mycpu_id_fetch_rx dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .allowIN         (allowIN),
    .jen             (jen),
    .offset          (offset),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .rs_value        (rs_value),
    .rt_value        (rt_value),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_inst         (ds_inst),
    .ds_pc           (ds_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    int          pulses;
    logic [31:0] off;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t        expq[$];
  logic [31:0] mem [256];
  logic [31:0] rf [32];
  bit          use_rf = 1'b1;
  logic [31:0] man_rs = 32'd0;
  logic [31:0] man_rt = 32'd0;
  bit          pend = 1'b0;
  logic [31:0] pend_pc = 32'd0;
  logic [31:0] next_pc = 32'hbfc00000;
  bit          front_pulsed = 1'b0;
  bit          last_allow = 1'b0;

  assign rs_value = use_rf ? rf[rs_addr] : man_rs;
  assign rt_value = use_rf ? rf[rt_addr] : man_rt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rs(input logic [31:0] i);
    return use_rf ? rf[i[25:21]] : man_rs;
  endfunction

  function automatic logic [31:0] ref_rt(input logic [31:0] i);
    return use_rf ? rf[i[20:16]] : man_rt;
  endfunction

  function automatic bit ref_taken(input logic [31:0] i);
    logic signed [31:0] a;
    logic signed [31:0] b;
    a = ref_rs(i);
    b = ref_rt(i);
    case (i[31:26])
      6'd4:    return a == b;
      6'd5:    return a != b;
      6'd6:    return a <= 0;
      6'd7:    return a > 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_off(input logic [31:0] i);
    logic signed [31:0] v;
    v = $signed(i[15:0]);
    return v * 4;
  endfunction

  task automatic model_clear();
    expq.delete();
    pend = 1'b0;
    front_pulsed = 1'b0;
  endtask

  // One clock: drive at negedge, then check ID contents against the queue.
  task automatic cycle(input bit want_en, input bit es);
    bit   issue;
    bit   exp_jen;
    ent_t f;
    @(negedge clk);
    es_allowin = es;
    inst_sram_rdata = pend ? mem[pend_pc[9:2]] : 32'hdeadbeef;
    #1;
    last_allow = allowIN;
    issue = want_en && allowIN;
    inst_sram_en = issue;
    inst_sram_addr = next_pc;
    #1;
    chk("valid_vs_queue", 32'(ds_to_es_valid && expq.size() == 0), 0);
    if (ds_to_es_valid && expq.size() != 0) begin
      f = expq[0];
      chk("ds_pc", ds_pc, f.pc);
      chk("ds_inst", ds_inst, f.inst);
      chk("offset", offset, ref_off(f.inst));
      chk("rs_addr", 32'(rs_addr), 32'(f.inst[25:21]));
      exp_jen = ref_taken(f.inst) && !front_pulsed;
      chk("jen", 32'(jen), 32'(exp_jen));
      if (exp_jen) front_pulsed = 1'b1;
      if (es) begin
        void'(expq.pop_front());
        front_pulsed = 1'b0;
      end
    end else begin
      chk("jen_idle", 32'(jen), 0);
    end
    if (issue) expq.push_back('{next_pc, mem[next_pc[9:2]]});
    pend = issue;
    pend_pc = next_pc;
    if (issue) next_pc = next_pc + 32'd4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    inst_sram_en = 1'b0;
    es_allowin = 1'b1;
    #2;
    chk("rst_valid", 32'(ds_to_es_valid), 0);
    chk("rst_allowIN", 32'(allowIN), 1);
    chk("rst_pc", ds_pc, RESET_PC);
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  vec_t vecs[10];
  int   pulses;
  logic [5:0] ops[6];

  initial begin
    vecs[0] = '{"beq_eq",    32'h1085000C, 32'd5, 32'd5, 1, 32'h00000030};
    vecs[1] = '{"beq_ne",    32'h1085000C, 32'd5, 32'd6, 0, 32'h00000030};
    vecs[2] = '{"bne_stall", 32'h1485FFFE, 32'd1, 32'd2, 1, 32'hFFFFFFF8};
    vecs[3] = '{"blez_0",    32'h18800004, 32'd0, 32'd9, 1, 32'h00000010};
    vecs[4] = '{"bgtz_0",    32'h1C800004, 32'd0, 32'd9, 0, 32'h00000010};
    vecs[5] = '{"blez_min",  32'h18808000, 32'h80000000, 32'd0, 1,
                32'hFFFE0000};
    vecs[6] = '{"bgtz_1",    32'h1C800001, 32'd1, 32'd0, 1, 32'h00000004};
    vecs[7] = '{"bgtz_min",  32'h1C800001, 32'h80000000, 32'd0, 0,
                32'h00000004};
    vecs[8] = '{"blez_1",    32'h18800001, 32'd1, 32'd0, 0, 32'h00000004};
    vecs[9] = '{"addu",      32'h00851021, 32'd3, 32'd3, 0, 32'h00004084};
    ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd0};

    for (int i = 0; i < 32; i++)
      rf[i] = (i % 5 == 0) ? (32'h80000000 | 32'(i)) : $urandom_range(0, 3);
    for (int i = 0; i < 256; i++)
      mem[i] = {ops[$urandom_range(0, 5)], 26'($urandom)};

    #12;
    resetn = 1'b1;

    // Branch table: each word loaded alone, then held 4 stalled cycles.
    use_rf = 1'b0;
    for (int v = 0; v < 10; v++) begin
      do_reset();
      man_rs = vecs[v].rs;
      man_rt = vecs[v].rt;
      next_pc = 32'hbfc00100;
      mem[64] = vecs[v].inst;
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        cycle(1'b0, 1'b0);
        pulses += int'(jen);
      end
      chk({vecs[v].name, "_pulses"}, 32'(pulses), 32'(vecs[v].pulses));
      chk({vecs[v].name, "_off"}, offset, vecs[v].off);
      cycle(1'b0, 1'b1);
    end
    use_rf = 1'b1;

    // Back-to-back stream, then a 3-cycle EX stall and drain.
    do_reset();
    next_pc = 32'hbfc00000;
    cycle(1'b1, 1'b1);
    chk("stream_v0", 32'(ds_to_es_valid), 0);
    cycle(1'b1, 1'b1);
    chk("stream_v1", 32'(ds_to_es_valid), 0);
    cycle(1'b1, 1'b1);
    chk("stream_v2", 32'(ds_to_es_valid), 1);
    chk("stream_pc0", ds_pc, 32'hbfc00000);
    chk("stream_allow", 32'(last_allow), 1);
    cycle(1'b1, 1'b1);
    chk("stream_pc1", ds_pc, 32'hbfc00004);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b1);
      chk("stream_allow", 32'(last_allow), 1);
    end
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
    chk("stall_allowIN", 32'(last_allow), 0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1);
    chk("stall_drained", 32'(expq.size()), 0);

    // Async reset while the hold buffer is full.
    do_reset();
    next_pc = 32'hbfc00000;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0);
    chk("pre_rst_allowIN", 32'(allowIN), 0);
    #1;
    resetn = 1'b0;
    inst_sram_en = 1'b0;
    #1;
    chk("arst_valid", 32'(ds_to_es_valid), 0);
    chk("arst_allowIN", 32'(allowIN), 1);
    chk("arst_jen", 32'(jen), 0);
    chk("arst_pc", ds_pc, RESET_PC);
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1);
      chk("arst_no_stale", 32'(ds_to_es_valid), 0);
    end

    // Random fetch/stall traffic checked against the in-order queue.
    do_reset();
    next_pc = 32'hbfc00000;
    for (int k = 0; k < 600; k++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);
    chk("rand_drained", 32'(expq.size()), 0);
    chk("rand_idle", 32'(ds_to_es_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mycpu_id_fetch_rx.md
Name: mycpu_id_fetch_rx

Overview:
- Decode-side receiver for the instruction-fetch interface. It consumes the instruction SRAM read data returned for each fetch request and holds it in the ID pipeline register.
- Buffers the fetched word when EX stalls, using a 1-entry hold buffer.
- Drives the back-pressure signal allowIN and resolves conditional branches. It returns jen and offset to the fetch stage.
- Sits between the fetch stage / instruction SRAM and the EX stage. It also reads the register file.

Parameters:
- RESET_PC, 32'hbfc00000, PC value reported for an empty ID register after reset.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- inst_sram_en  input  1  fetch request strobe from fetch stage; read data returns the next cycle.
- inst_sram_addr  input  32  PC of the request.
- inst_sram_rdata  input  32  instruction word, valid the cycle after inst_sram_en.
- allowIN  output  1  fetch may issue a new request this cycle.
- jen  output  1  branch taken; one-cycle pulse per taken branch.
- offset  output  32  sign-extended branch offset (imm<<2).
- rs_addr  output  5  register-file read address, instr[25:21].
- rt_addr  output  5  register-file read address, instr[20:16].
- rs_value  input  32  register-file read data for rs.
- rt_value  input  32  register-file read data for rt.
- es_allowin  input  1  EX stage accepts an instruction this cycle.
- ds_to_es_valid  output  1  ID register holds a valid instruction.
- ds_inst  output  32  instruction in the ID register.
- ds_pc  output  32  PC of the instruction in the ID register.

Behaviour:
- Reset (resetn low, async) clears req_pending, ds_valid, hold_valid and br_done. ds_inst=0, ds_pc=RESET_PC, jen=0, allowIN=1, ds_to_es_valid=0.
- req_pending: registered copy of inst_sram_en. req_pc: registered copy of inst_sram_addr, captured when inst_sram_en=1.
- Arrival:
  - A response is present in the cycle where req_pending=1.
  - The word is inst_sram_rdata with PC req_pc. It must be captured that cycle, because SRAM data is not held.
- ds_allowin = !ds_valid || es_allowin.
- Capture priority each cycle:
  - If hold_valid and ds_allowin: the hold entry moves to the ID register.
    - If a response also arrives, it goes into the hold buffer; hold stays full.
  - Else if response and ds_allowin: the response goes directly into the ID register.
  - Else if response and !ds_allowin: the response goes into the hold buffer, and hold_valid is set.
  - A response arriving with hold_valid=1 and ds_allowin=0 is a protocol violation, prevented by allowIN. Flag it with a simulation-only assertion.
- ds_valid:
  - Set when the ID register loads.
  - Cleared when es_allowin=1 and nothing loads that cycle.
- allowIN = !hold_valid && !(req_pending && !ds_allowin). At most one word is ever in flight beyond the ID register.
- Branch decode uses the ID register and is combinational on ds_inst/rs_value/rt_value:
  - beq (opcode 000100): taken when rs==rt.
  - bne (000101): taken when rs!=rt.
  - blez (000110): taken when rs is signed <=0.
  - bgtz (000111): taken when rs is signed >0.
  - All other opcodes are not branches.
- offset = {{14{ds_inst[15]}}, ds_inst[15:0], 2'b00}. The value is driven regardless of jen.
- jen = ds_valid && taken && !br_done.
  - br_done is set on the cycle jen=1 if the instruction does not leave ID.
  - br_done is cleared when the ID register loads a new instruction.
  - A branch stalled k cycles yields exactly one jen pulse.
- The delay-slot instruction is not killed; it proceeds normally.
- Reset mid-operation discards the pending response and the hold entry. No stale word is delivered after resetn rises.

Decomposition:
- Shared package mycpu_pkg:
  - Opcode constants OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ.
  - RESET_PC constant.
  - Function sext_br_offset.
- One natural sub-module, mycpu_br_cmp: pure comparator taking opcode, rs_value and rt_value and returning taken.

Test Plan:
- Reset then stream: inst_sram_en=1 each cycle at addr 0xbfc00000, +4, …, es_allowin=1 -> ds_to_es_valid rises 2 cycles after the first request; ds_pc follows 0xbfc00000, 0xbfc00004 with 1/cycle throughput; allowIN stays 1.
- EX stall: es_allowin=0 for 3 cycles while a response arrives with ds_valid=1 -> word enters hold, allowIN=0. When es_allowin=1, hold drains to ID in order and no word is lost or duplicated.
- beq taken: ds_inst=0x1085000C (beq a0,a1,+12), rs_value=rt_value=5 -> jen=1 for exactly one cycle, offset=0x00000030.
- Stalled bne: bne with imm 0xFFFE, unequal operands, es_allowin=0 for 4 cycles -> a single jen pulse, offset=0xFFFFFFF8.
- blez/bgtz boundaries: rs_value=0 gives blez taken and bgtz not taken. rs_value=0x80000000 gives blez taken. rs_value=1 gives bgtz taken.
- Async reset: assert resetn=0 mid-stall with hold_valid=1 -> immediately ds_to_es_valid=0, allowIN=1, jen=0 and ds_pc=0xbfc00000. After release, no stale instruction appears.
